// File: rtl/rr_mult_pkg.sv
// Shared types and helpers for the round-robin sequential multiplier:
// FSM state encoding, sub-multiplier width helper and partial-product step codes.
package rr_mult_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Step code: bit 0 selects the high field of a, bit 1 the high field of b.
    localparam logic [1:0] PP_LL = 2'b00;
    localparam logic [1:0] PP_HL = 2'b01;
    localparam logic [1:0] PP_LH = 2'b10;
    localparam logic [1:0] PP_HH = 2'b11;

    function automatic int sub_mul_width(input int hi_w, input int lo_w);
        return (hi_w > lo_w) ? hi_w : lo_w;
    endfunction

endpackage

// File: rtl/rr_subprod_mul.sv
// Combinational unsigned M x M multiplier shared by all partial-product steps.
module rr_subprod_mul #(
    parameter int M = 18
) (
    input  logic [M-1:0]   x,
    input  logic [M-1:0]   y,
    output logic [2*M-1:0] prod
);

    assign prod = {{M{1'b0}}, x} * {{M{1'b0}}, y};

endmodule

// File: rtl/rr_mult_seq.sv
// Sequential split-operand multiplier: four partial products on one shared
// sub-multiplier. Optional RR_MULT_SEQ_APPROX_LSB_EN makes the accumulator's low APPROX_K bits carry-free.
module rr_mult_seq
    import rr_mult_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LO_W     = 14,
    parameter int APPROX_K = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int HI_W = WIDTH - LO_W;
    localparam int M    = sub_mul_width(HI_W, LO_W);
    localparam int PW   = 2 * WIDTH;
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> HI_W;

    // A split point of zero makes the accumulate step a plain exact add.
`ifdef RR_MULT_SEQ_APPROX_LSB_EN
    localparam int ACC_SPLIT = APPROX_K;
`else
    localparam int ACC_SPLIT = 0;
`endif

    function automatic logic [PW-1:0] acc_add(input logic [PW-1:0] x, input logic [PW-1:0] t);
        logic [PW-1:0] lo_mask;
        lo_mask = ~({PW{1'b1}} << ACC_SPLIT);
        return (((x >> ACC_SPLIT) + (t >> ACC_SPLIT)) << ACC_SPLIT) | ((x | t) & lo_mask);
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc_q, p_q;
    logic [1:0]        step;
    logic [M-1:0]      m_a, m_b;
    logic [2*M-1:0]    m_p;
    logic [PW-1:0]     term, acc_next;
    int unsigned       term_sh;

    always_comb begin
        case (state_q)
            PP1:     step = PP_HL;
            PP2:     step = PP_LH;
            PP3:     step = PP_HH;
            default: step = PP_LL;
        endcase
    end

    assign m_a = step[0] ? M'(a_q >> LO_W) : M'(a_q & LO_MASK);
    assign m_b = step[1] ? M'(b_q >> LO_W) : M'(b_q & LO_MASK);

    rr_subprod_mul #(.M(M)) u_sub_mul (
        .x    (m_a),
        .y    (m_b),
        .prod (m_p)
    );

    assign term_sh  = LO_W * (32'(step[0]) + 32'(step[1]));
    assign term     = PW'(m_p) << term_sh;
    assign acc_next = acc_add(acc_q, term);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = PP0;
            PP0:     state_d = PP1;
            PP1:     state_d = PP2;
            PP2:     state_d = PP3;
            PP3:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
            end
            if (state_q == PP0 || state_q == PP1 || state_q == PP2 || state_q == PP3) begin
                acc_q <= acc_next;
            end
            if (state_q == PP3) begin
                p_q <= acc_next;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_rr_mult_seq.sv
// Directed + randomized bench for rr_mult_seq, checked against a behavioural
// product model (honours RR_MULT_SEQ_APPROX_LSB_EN when defined).
module tb_rr_mult_seq;

    localparam int W    = 32;
    localparam int LO   = 14;
    localparam int K    = 20;
    localparam int PW   = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mult_seq #(.WIDTH(W), .LO_W(LO), .APPROX_K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    // Expected product: exact a*b, or the four shifted field products summed
    // with a carry-free low region when the approximate build is selected.
    function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef RR_MULT_SEQ_APPROX_LSB_EN
        logic [PW-1:0] acc, t, lo_part, hi_part;
        logic [PW-1:0] xl, xh, yl, yh;
        logic [PW-1:0] terms[4];
        xl = PW'(x) % (PW'(1) << LO);
        xh = PW'(x) / (PW'(1) << LO);
        yl = PW'(y) % (PW'(1) << LO);
        yh = PW'(y) / (PW'(1) << LO);
        terms[0] = xl * yl;
        terms[1] = (xh * yl) << LO;
        terms[2] = (xl * yh) << LO;
        terms[3] = (xh * yh) << (2 * LO);
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            t = terms[i];
            if (K >= PW) begin
                acc = acc | t;
            end else begin
                hi_part = ((acc >> K) + (t >> K)) << K;
                lo_part = (acc | t) & ((PW'(1) << K) - PW'(1));
                acc = hi_part | lo_part;
            end
        end
        return acc;
`else
        return PW'(x) * PW'(y);
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction; optionally stall the consumer and poke in_valid while busy.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input int stall, input bit poke);
        logic [PW-1:0] exp;
        int edges;
        int waitc;
        exp = model(ta, tb_v);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("in_ready_idle", in_ready, 1'b1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        check("in_ready_busy", in_ready, 1'b0);
        while (!out_valid && edges < 20) begin
            if (poke) begin
                in_valid = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end
            @(posedge clk); #1;
            edges++;
            if (poke && !out_valid) check("busy_no_ready", in_ready, 1'b0);
        end
        check("latency", edges, 5);
        check("product", p, exp);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = W'($urandom);
            end
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_p", p, exp);
            if (poke) check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", out_valid, 1'b0);
        check("back_idle", in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_p", p, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle must do nothing
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_out_ready", out_valid, 1'b0);

        run_txn(W'(3), W'(5), 0, 1'b0);
`ifndef RR_MULT_SEQ_APPROX_LSB_EN
        check("small_const", p, PW'(15));
`endif
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
`ifndef RR_MULT_SEQ_APPROX_LSB_EN
        check("max_const", p, 64'hFFFF_FFFE_0000_0001);
`endif
        run_txn(32'h0000_7FFF, 32'h0000_3FFF, 0, 1'b0);
`ifndef RR_MULT_SEQ_APPROX_LSB_EN
        check("mid_const", p, 64'h1FFF_4001);
`endif

        // backpressure plus in_valid while busy, then a clean follow-up
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1);
        run_txn(32'h0BAD_F00D, 32'h0000_0011, 0, 1'b0);

        // reset during PP2
        a = 32'h1234; b = 32'h5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_p", p, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_valid", out_valid, 1'b0);
        end
        run_txn(W'(6), W'(7), 0, 1'b0);
`ifndef RR_MULT_SEQ_APPROX_LSB_EN
        check("post_rst_const", p, PW'(42));
`endif

        // randomized sweep with occasional stalls
        for (int i = 0; i < 200; i++) begin
            run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mult_seq.md
Name: rr_mult_seq

Overview:
- Parametrised sequential successor to the combinational split-operand multipliers.
- Splits each operand into high and low fields and computes the four partial products one per cycle on a single shared sub-multiplier, accumulating them into a 2*WIDTH-bit product.
- Uses valid/ready handshakes on input and output. Sits between operand-issue logic and result consumers in the multiplier evaluation datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4.
- LO_W, 14, low-field width; 1 ≤ LO_W ≤ WIDTH-1. High field width HI_W = WIDTH-LO_W.
- APPROX_K, 20, width of the approximate low region of the accumulator; 0 ≤ APPROX_K ≤ 2*WIDTH. Used only when APPROX_LSB_EN is defined.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product, unsigned

Behaviour:
- Reset values (async, on rst_n=0): state=IDLE, in_ready=1, out_valid=0, p=0, accumulator=0, captured operands=0.
- Operand fields: AL=a[LO_W-1:0], AH=a[WIDTH-1:LO_W], BL and BH likewise.
- Sub-multiplier: a single M×M unsigned unit, M=max(HI_W,LO_W). Narrower fields are zero-extended to M bits.
- FSM states: IDLE, PP0, PP1, PP2, PP3, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a and b, clear the accumulator, go to PP0.
- PP0: acc ← AL*BL. Go to PP1.
- PP1: acc ← acc + (AH*BL << LO_W). Go to PP2.
- PP2: acc ← acc + (AL*BH << LO_W). Go to PP3.
- PP3: acc ← acc + (AH*BH << 2*LO_W). Go to DONE. p is registered from the final sum on this edge.
- DONE:
  - out_valid=1; p is held stable.
  - On out_ready: go to IDLE and drop out_valid.
- Accumulator arithmetic is 2*WIDTH bits wide. The exact result never overflows.
- Latency: out_valid rises exactly 5 rising edges after the accepting edge. Minimum initiation interval is 6 cycles.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored and no operands are captured.
- out_valid and p remain stable under out_ready=0 for any number of cycles.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation aborts immediately to reset values. No stale out_valid follows.

Optional Feature:
- Macro: RR_MULT_SEQ_APPROX_LSB_EN.
- Defined:
  - Each accumulate step splits at bit APPROX_K.
  - Low region: new_acc[APPROX_K-1:0] = acc_low | term_low (bitwise OR, no carry generated).
  - High region: exact add of acc>>APPROX_K and term>>APPROX_K.
  - APPROX_K=0 reduces to exact behaviour.
- Undefined: fully exact addition; APPROX_K is ignored.

Decomposition:
- Package rr_mult_pkg holds:
  - the FSM state enum (3-bit encoding);
  - a width helper function for M=max(HI_W,LO_W);
  - the PP-step index constants.
- Sub-module rr_subprod_mul: combinational unsigned M×M multiplier, parameter M, with output width 2*M. Instantiated once.
- Accumulate and approximate-add logic stays in rr_mult_seq.

Test Plan:
1. Exact build: a=3, b=5, in_valid pulsed in IDLE → after 5 edges out_valid=1 and p=15; out_ready=1 → IDLE, in_ready=1.
2. Exact build: a=b=0xFFFFFFFF → p=0xFFFFFFFE00000001. Then a=0x7FFF, b=0x3FFF → p=0x1FFF4001.
3. Backpressure and busy input: hold out_ready=0 for 10 cycles → p stable and out_valid=1 throughout. New in_valid during PP1..DONE → ignored and in_ready=0; the following transaction produces the correct product after DONE→IDLE.
4. Reset mid-operation: rst_n=0 during PP2 → all outputs at reset values in the same cycle. After release, a=6, b=7 → p=42.
5. RR_MULT_SEQ_APPROX_LSB_EN with APPROX_K=20: a=0x7FFF, b=0x3FFF → p=0x1FEFC001, not the exact 0x1FFF4001.
6. RR_MULT_SEQ_APPROX_LSB_EN with APPROX_K=0: random sweep of 1000 operand pairs → all results equal the exact a*b. Also repeat with WIDTH=16, LO_W=8 and with WIDTH=8, LO_W=3 against the exact reference.
